// File: rtl/pulse_seq_pkg.sv
// ============================================================================
// pulse_seq_pkg : shared types, defaults and window compare for pulse_seq
// Rev 1.0
// ============================================================================
`default_nettype none

package pulse_seq_pkg;

    localparam int DEF_CNT_W = 32;
    localparam int DEF_ATT_W = 7;
    // Wide enough for any CNT_W up to 63 plus its carry bit.
    localparam int WIN_W     = 65;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic logic win_hit(input logic [WIN_W-1:0] lo,
                                     input logic [WIN_W-1:0] hi,
                                     input logic [WIN_W-1:0] x);
        return (x >= lo) && (x < hi);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pulse_train_gen.sv
// ============================================================================
// pulse_train_gen : running-edge refocusing train following the seed slot
// Rev 1.0
// ============================================================================
`default_nettype none

module pulse_train_gen #(
    parameter int CNT_W = 32,
    parameter int TRN_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             run_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] start_i,
    input  logic [CNT_W-1:0] width_i,
    input  logic [CNT_W-1:0] space_i,
    input  logic [TRN_W-1:0] reps_i,
    output logic             hit_o
);

    localparam int PW = CNT_W + 2;

    logic [PW-1:0]    rise_q;
    logic [PW-1:0]    fall_q;
    logic [TRN_W-1:0] nrise_q;
    logic [TRN_W-1:0] nfall_q;

    logic             armed_d;
    logic             live_d;
    logic             rise_d;
    logic             fall_d;
    logic [TRN_W:0]   up_d;
    logic [TRN_W:0]   dn_d;

    assign armed_d = en_i && (reps_i != '0) && (space_i != '0) && (width_i != '0);
    assign live_d  = armed_d && (cnt_i != '0);

    // Overlapping repetitions are tracked as rises-seen minus falls-seen, so a
    // merged train stays high while any repetition still covers the tick.
    assign rise_d = live_d && (rise_q == {2'b00, cnt_i}) && (nrise_q < reps_i);
    assign fall_d = live_d && (fall_q == {2'b00, cnt_i}) && (nfall_q < nrise_q);

    assign up_d  = {1'b0, nrise_q} + {{TRN_W{1'b0}}, rise_d};
    assign dn_d  = {1'b0, nfall_q} + {{TRN_W{1'b0}}, fall_d};
    assign hit_o = live_d && (up_d > dn_d);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rise_q  <= '0;
            fall_q  <= '0;
            nrise_q <= '0;
            nfall_q <= '0;
        end else if (run_i) begin
            if (cnt_i == '0) begin
                rise_q  <= {2'b00, start_i} + {2'b00, space_i};
                fall_q  <= {2'b00, start_i} + {2'b00, space_i} + {2'b00, width_i};
                nrise_q <= '0;
                nfall_q <= '0;
            end else begin
                if (rise_d) begin
                    rise_q  <= rise_q + {2'b00, space_i};
                    nrise_q <= nrise_q + TRN_W'(1);
                end
                if (fall_d) begin
                    fall_q  <= fall_q + {2'b00, space_i};
                    nfall_q <= nfall_q + TRN_W'(1);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/pulse_seq.sv
// ============================================================================
// pulse_seq : NSLOT-slot pulse sequencer with train, sync, attenuator, blanking
// Rev 1.0
// ============================================================================
`default_nettype none

module pulse_seq
    import pulse_seq_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int NSLOT = 4,
    parameter int ATT_W = DEF_ATT_W,
    parameter int TRN_W = 8
) (
    input  logic                   clk_pll,
    input  logic                   resetn,
    input  logic                   enable,
    input  logic [CNT_W-1:0]       period,
    input  logic [CNT_W-1:0]       sync_width,
    input  logic [NSLOT*CNT_W-1:0] slot_start,
    input  logic [NSLOT*CNT_W-1:0] slot_width,
    input  logic [NSLOT-1:0]       slot_en,
    input  logic [TRN_W-1:0]       train_n,
    input  logic [CNT_W-1:0]       train_space,
    input  logic [ATT_W-1:0]       att_pump,
    input  logic [ATT_W-1:0]       att_probe,
    input  logic [CNT_W-1:0]       att_lo,
    input  logic [CNT_W-1:0]       att_hi,
    input  logic                   block_en,
    input  logic [CNT_W-1:0]       blank_lo,
    input  logic [CNT_W-1:0]       blank_hi,
    output logic                   sync_on,
    output logic                   pulse_on,
    output logic [NSLOT-1:0]       pulse_ch,
    output logic [ATT_W-1:0]       att1,
    output logic                   inhib,
    output logic                   cycle_start,
    output logic                   busy
);

    function automatic logic [WIN_W-1:0] ext(input logic [CNT_W:0] v);
        return {{(WIN_W-CNT_W-1){1'b0}}, v};
    endfunction

    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;

    logic [CNT_W-1:0]       per_q;
    logic [CNT_W-1:0]       syncw_q;
    logic [NSLOT*CNT_W-1:0] sst_q;
    logic [NSLOT*CNT_W-1:0] swd_q;
    logic [NSLOT-1:0]       sen_q;
    logic [TRN_W-1:0]       tn_q;
    logic [CNT_W-1:0]       tsp_q;
    logic [ATT_W-1:0]       apu_q;
    logic [ATT_W-1:0]       apr_q;
    logic [CNT_W-1:0]       alo_q;
    logic [CNT_W-1:0]       ahi_q;
    logic                   ben_q;
    logic [CNT_W-1:0]       blo_q;
    logic [CNT_W-1:0]       bhi_q;

    logic                   sync_on_q;
    logic                   pulse_on_q;
    logic [NSLOT-1:0]       pulse_ch_q;
    logic [ATT_W-1:0]       att1_q;
    logic                   inhib_q;
    logic                   cycle_start_q;
    logic                   busy_q;

    logic                   wrap_d;
    logic                   latch_d;
    logic [WIN_W-1:0]       cnt_x_d;
    logic [NSLOT-1:0]       slot_hit_d;
    logic                   train_hit_d;
    logic [NSLOT-1:0]       pulse_ch_d;
    logic                   sync_d;
    logic                   probe_d;
    logic                   blank_d;

    assign wrap_d  = (cnt_q == per_q);
    assign latch_d = (state_q == IDLE) ? enable : wrap_d;
    assign cnt_x_d = ext({1'b0, cnt_q});

    for (genvar k = 0; k < NSLOT; k++) begin : g_slot
        logic [CNT_W:0] end_d;
        assign end_d = {1'b0, sst_q[k*CNT_W +: CNT_W]} + {1'b0, swd_q[k*CNT_W +: CNT_W]};
        assign slot_hit_d[k] = sen_q[k] &&
                               win_hit(ext({1'b0, sst_q[k*CNT_W +: CNT_W]}), ext(end_d), cnt_x_d);
    end

    pulse_train_gen #(
        .CNT_W (CNT_W),
        .TRN_W (TRN_W)
    ) u_train (
        .clk_i   (clk_pll),
        .rst_ni  (resetn),
        .run_i   (state_q == RUN),
        .cnt_i   (cnt_q),
        .en_i    (sen_q[NSLOT-1]),
        .start_i (sst_q[(NSLOT-1)*CNT_W +: CNT_W]),
        .width_i (swd_q[(NSLOT-1)*CNT_W +: CNT_W]),
        .space_i (tsp_q),
        .reps_i  (tn_q),
        .hit_o   (train_hit_d)
    );

    always_comb begin
        pulse_ch_d            = slot_hit_d;
        pulse_ch_d[NSLOT-1]   = slot_hit_d[NSLOT-1] | train_hit_d;
    end

    assign sync_d  = win_hit('0, ext({1'b0, syncw_q}), cnt_x_d);
    assign probe_d = win_hit(ext({1'b0, alo_q}), ext({1'b0, ahi_q}), cnt_x_d);
    assign blank_d = win_hit(ext({1'b0, blo_q}), ext({1'b0, bhi_q}), cnt_x_d);

    // Shadows only move at the cycle boundary so a host write never splits a cycle.
    always_ff @(posedge clk_pll or negedge resetn) begin
        if (!resetn) begin
            per_q   <= '0;
            syncw_q <= '0;
            sst_q   <= '0;
            swd_q   <= '0;
            sen_q   <= '0;
            tn_q    <= '0;
            tsp_q   <= '0;
            apu_q   <= '0;
            apr_q   <= '0;
            alo_q   <= '0;
            ahi_q   <= '0;
            ben_q   <= 1'b0;
            blo_q   <= '0;
            bhi_q   <= '0;
        end else if (latch_d) begin
            per_q   <= (period == '0) ? CNT_W'(1) : period;
            syncw_q <= sync_width;
            sst_q   <= slot_start;
            swd_q   <= slot_width;
            sen_q   <= slot_en;
            tn_q    <= train_n;
            tsp_q   <= train_space;
            apu_q   <= att_pump;
            apr_q   <= att_probe;
            alo_q   <= att_lo;
            ahi_q   <= att_hi;
            ben_q   <= block_en;
            blo_q   <= blank_lo;
            bhi_q   <= blank_hi;
        end
    end

    always_ff @(posedge clk_pll or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            sync_on_q     <= 1'b0;
            pulse_on_q    <= 1'b0;
            pulse_ch_q    <= '0;
            att1_q        <= '0;
            inhib_q       <= 1'b0;
            cycle_start_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            if (state_q == RUN) begin
                sync_on_q     <= sync_d;
                pulse_ch_q    <= pulse_ch_d;
                pulse_on_q    <= |pulse_ch_d;
                att1_q        <= probe_d ? apr_q : apu_q;
                inhib_q       <= ben_q && !blank_d;
                cycle_start_q <= (cnt_q == '0);
                busy_q        <= 1'b1;
            end else begin
                sync_on_q     <= 1'b0;
                pulse_ch_q    <= '0;
                pulse_on_q    <= 1'b0;
                att1_q        <= att_pump;
                inhib_q       <= 1'b0;
                cycle_start_q <= 1'b0;
                busy_q        <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    if (wrap_d) begin
                        cnt_q <= '0;
                        if (!enable) begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sync_on     = sync_on_q;
    assign pulse_on    = pulse_on_q;
    assign pulse_ch    = pulse_ch_q;
    assign att1        = att1_q;
    assign inhib       = inhib_q;
    assign cycle_start = cycle_start_q;
    assign busy        = busy_q;

endmodule

`default_nettype wire

// File: doc/pulse_seq.md
Name: pulse_seq

Overview:
- Parametrised successor to the two-pulse/pump-probe generator.
- Produces a repeating sequence on the 200 MHz PLL clock: NSLOT independently programmed pulse slots plus a CPMG-style refocusing train after the last slot.
- Also drives scope sync, main-attenuator select and blocking-switch outputs.
- All timing parameters are captured into shadow registers at the cycle boundary, so host updates never produce a partial or glitched cycle.

Parameters:
- CNT_W, 32, counter and timing-field width (clock ticks).
- NSLOT, 4, number of programmable pulse slots; slot NSLOT-1 is the train seed.
- ATT_W, 7, attenuator word width.
- TRN_W, 8, width of the train repetition count.

Ports:
- clk_pll  in  1  200 MHz clock.
- resetn  in  1  asynchronous active-low reset.
- enable  in  1  run request.
- period  in  CNT_W  cycle length minus 1.
- sync_width  in  CNT_W  sync high for counter < sync_width.
- slot_start  in  NSLOT*CNT_W  per-slot start tick; slot k at bits [k*CNT_W +: CNT_W].
- slot_width  in  NSLOT*CNT_W  per-slot width.
- slot_en  in  NSLOT  per-slot enable mask.
- train_n  in  TRN_W  extra repetitions of slot NSLOT-1.
- train_space  in  CNT_W  start-to-start spacing of train pulses.
- att_pump  in  ATT_W  attenuation outside the probe window.
- att_probe  in  ATT_W  attenuation inside the probe window.
- att_lo, att_hi  in  CNT_W each  probe window [att_lo, att_hi).
- block_en  in  1  blocking switch enable.
- blank_lo, blank_hi  in  CNT_W each  inhib released inside [blank_lo, blank_hi).
- sync_on  out  1  scope trigger.
- pulse_on  out  1  OR of all slot and train pulses.
- pulse_ch  out  NSLOT  per-slot pulse; the train appears on bit NSLOT-1.
- att1  out  ATT_W  main attenuator word.
- inhib  out  1  blocking switch.
- cycle_start  out  1  one-cycle strobe when counter = 0.
- busy  out  1  high while in RUN.

Behaviour:
- Reset (async, resetn=0):
  - All outputs 0, counter 0, state IDLE, shadows 0.
  - Reset mid-cycle drops every output on the same edge.
- States:
  - IDLE -> RUN when enable=1. Shadow registers latch all timing inputs; counter=0.
  - RUN: counter increments each clock. When counter = shadow period, it wraps to 0, re-latches the shadows and pulses cycle_start.
  - RUN -> IDLE when enable=0 is sampled at the wrap. A stop request mid-cycle completes the current cycle.
- Shadow period below 1 is treated as 1, giving a minimum cycle of 2 ticks.
- All outputs are registered and decode the counter value of the previous clock (latency 1). Decodes use shadow values only.
- Slot k: pulse_ch[k] = slot_en[k] && start_k <= cnt < start_k + width_k.
  - width 0 means the slot never fires.
  - The end sum is computed in CNT_W+1 bits. An end beyond period truncates at the wrap; the pulse never spans cycles.
- Train: after slot NSLOT-1, repetitions j = 1..train_n are high for cnt in [start + j*space, start + j*space + width).
  - Implemented with running edge registers (next_rise, next_fall, rep count) reloaded at cnt = 0. No multipliers.
  - Requires slot_en[NSLOT-1] = 1.
  - train_n = 0 or train_space = 0 disables the train.
  - If train_space <= width, pulses merge into one continuous high; the rep count still advances.
  - Repetitions whose rise exceeds period are dropped.
- pulse_on is the OR of pulse_ch. Overlapping slots are legal.
- sync_on = cnt < sync_width.
- att1 = att_probe inside [att_lo, att_hi), else att_pump. An empty window (lo >= hi) gives att_pump throughout.
- inhib = block_en && !(blank_lo <= cnt < blank_hi).
- In IDLE: pulse_on, pulse_ch, sync_on and inhib are 0, and att1 = att_pump (live input).

Decomposition:
- Package pulse_seq_pkg holds:
  - CNT_W, ATT_W defaults.
  - State enum {IDLE, RUN}.
  - A window-compare function (lo <= x < hi, with an overflow-safe end).
- One sub-module, pulse_train_gen, holds the running-edge train logic. It is instantiated once, on slot NSLOT-1.

Test Plan:
1. NSLOT=4, period=99, slot0 start 0 width 10, slot1 start 40 width 5, others disabled -> pulse_on high at cnt 0-9 and 40-44, observed one clock later; cycle_start every 100 clocks.
2. Slot3 start 20 width 4, train_n=3, train_space=10 -> pulse_ch[3] high at 20-23, 30-33, 40-43, 50-53; nothing after 53.
3. period changed from 99 to 49 at cnt 30 -> current cycle still 100 ticks; next cycle 50 ticks.
4. enable dropped at cnt 10 -> busy stays high until the wrap at 99, then IDLE with all pulse outputs 0.
5. att_lo=15, att_hi=60, block_en=1, blank 55-70 -> att1=att_probe at cnt 15-59; inhib=0 at cnt 55-69 and 1 elsewhere.
6. resetn asserted at cnt 42 during a pulse -> all outputs 0 immediately; after release with enable=1, the sequence restarts at cnt 0.
